// File: rtl/mul_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : mul_pkg                                                      |
// | Description : Shared types and sizing helpers for the shared multiplier.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

  // Counter width able to hold the value WIDTH itself (the "done" count).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_shift_add_core.sv
// +----------------------------------------------------------------------------+
// | Module      : mul_shift_add_core                                           |
// | Description : Sequential unsigned shift-add multiplier, one bit per step.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module mul_shift_add_core
  import mul_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH);

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] w_addend;

  assign w_addend = {{WIDTH{1'b0}}, r_a} << r_cnt;
  assign done     = (r_cnt == c_last);
  assign product  = r_acc;

  // Step is ignored once WIDTH partial products have been summed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_a   <= a_in;
      r_b   <= b_in;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (step && !done) begin
      if (r_b[0]) begin
        r_acc <= r_acc + w_addend;
      end
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_rr_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module      : mul_rr_sequencer                                             |
// | Description : Round-robin sharing of one shift-add multiplier by two       |
// |               requesters, with an ID-tagged held response channel.        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module mul_rr_sequencer
  import mul_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               req1_ready,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [2*WIDTH-1:0] resp_product,
  output logic               busy
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_rr_ptr;
  logic               r_id;
  logic               w_grant0;
  logic               w_grant1;
  logic               w_accept;
  logic               w_load;
  logic               w_step;
  logic               w_done;
  logic [WIDTH-1:0]   w_a_sel;
  logic [WIDTH-1:0]   w_b_sel;
  logic [2*WIDTH-1:0] w_product;

  // rr_ptr names the requester that wins a tie.
  assign w_grant0 = req0_valid && (!req1_valid || !r_rr_ptr);
  assign w_grant1 = req1_valid && (!req0_valid ||  r_rr_ptr);
  assign w_accept = (r_state == ST_IDLE) && ena && rst_n && (req0_valid || req1_valid);
  assign w_a_sel  = w_grant1 ? req1_a : req0_a;
  assign w_b_sel  = w_grant1 ? req1_b : req0_b;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          req0_ready  = w_grant0;
          req1_ready  = w_grant1;
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // The done check costs one extra cycle, giving WIDTH+1 total latency.
        if (ena) begin
          if (w_done) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_step = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (ena && resp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= 1'b0;
      r_id     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_rr_ptr <= w_grant0;
        r_id     <= w_grant1;
      end
    end
  end

  mul_shift_add_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_load),
    .step    (w_step),
    .a_in    (w_a_sel),
    .b_in    (w_b_sel),
    .product (w_product),
    .done    (w_done)
  );

  assign resp_valid   = (r_state == ST_RESP);
  assign resp_id      = r_id;
  assign resp_product = w_product;
  assign busy         = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mul_rr_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_mul_rr_sequencer                                          |
// | Description : Scoreboard bench for the round-robin shared multiplier.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mul_rr_sequencer;

  localparam int WIDTH = 4;

  typedef struct packed {
    logic       id;
    logic [7:0] product;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       req0_valid = 1'b0;
  logic [3:0] req0_a = '0;
  logic [3:0] req0_b = '0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [3:0] req1_a = '0;
  logic [3:0] req1_b = '0;
  logic       req1_ready;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic       resp_id;
  logic [7:0] resp_product;
  logic       busy;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   id;
  exp_t held;

  mul_rr_sequencer #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .req0_valid   (req0_valid),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_ready   (req1_ready),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_product (resp_product),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a grant, pushes the expected product, then drops the winner's valid.
  task automatic wait_accept(output int gid);
    exp_t e;
    gid = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        check("ready_onehot", {31'b0, req0_ready & req1_ready}, 0);
        gid       = req1_ready ? 1 : 0;
        e.id      = req1_ready;
        e.product = req1_ready ? ({4'b0, req1_a} * {4'b0, req1_b})
                               : ({4'b0, req0_a} * {4'b0, req0_b});
        exp_q.push_back(e);
        acc_cyc = cyc + 1;
        tick();
        if (gid == 0) req0_valid = 1'b0;
        else          req1_valid = 1'b0;
        return;
      end
      tick();
    end
    check("accept_timeout", 1, 0);
  endtask

  task automatic wait_valid(input int lat);
    for (int i = 0; i < 60; i++) begin
      if (resp_valid) begin
        check("latency", cyc - acc_cyc, lat);
        return;
      end
      tick();
    end
    check("resp_timeout", 0, 1);
  endtask

  task automatic consume();
    exp_t e;
    resp_ready = 1'b1;
    #1;
    check("resp_valid", {31'b0, resp_valid}, 1);
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("resp_id", {31'b0, resp_id}, {31'b0, e.id});
      check("resp_product", {24'b0, resp_product}, {24'b0, e.product});
    end
    tick();
    check("resp_drop", {31'b0, resp_valid}, 0);
    check("busy_drop", {31'b0, busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    ena        = 1'b1;
    resp_ready = 1'b1;
    req0_valid = 1'b1;
    repeat (2) tick();
    check("rst_resp_valid", {31'b0, resp_valid}, 0);
    check("rst_busy",       {31'b0, busy}, 0);
    check("rst_product",    {24'b0, resp_product}, 0);
    check("rst_id",         {31'b0, resp_id}, 0);
    check("rst_ready0",     {31'b0, req0_ready}, 0);
    req0_valid = 1'b0;
    rst_n      = 1'b1;
    tick();

    // single jobs
    req0_a = 4'd3; req0_b = 4'd4; req0_valid = 1'b1;
    wait_accept(id);
    check("t1_grant", id, 0);
    wait_valid(5);
    consume();

    req1_a = 4'd15; req1_b = 4'd15; req1_valid = 1'b1;
    wait_accept(id);
    check("t2_grant", id, 1);
    wait_valid(5);
    consume();

    req0_a = 4'd0; req0_b = 4'd9; req0_valid = 1'b1;
    wait_accept(id);
    wait_valid(5);
    consume();

    // round-robin from a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req0_a = 4'd7; req0_b = 4'd2; req0_valid = 1'b1;
    req1_a = 4'd5; req1_b = 4'd3; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_accept(id);
      check("t3_order", id, k % 2);
      if (k < 2 && id == 0) begin
        req0_a = 4'd9; req0_b = 4'd9; req0_valid = 1'b1;
      end else if (k < 2 && id == 1) begin
        req1_a = 4'd11; req1_b = 4'd13; req1_valid = 1'b1;
      end
      wait_valid(5);
      consume();
    end

    // backpressure on the response channel
    req0_a = 4'd4; req0_b = 4'd13; req0_valid = 1'b1;
    wait_accept(id);
    resp_ready = 1'b0;
    wait_valid(5);
    req1_a = 4'd1; req1_b = 4'd1; req1_valid = 1'b1;
    held = (exp_q.size() != 0) ? exp_q[0] : '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      check("stall_valid",   {31'b0, resp_valid}, 1);
      check("stall_product", {24'b0, resp_product}, {24'b0, held.product});
      check("stall_id",      {31'b0, resp_id}, {31'b0, held.id});
      check("stall_ready1",  {31'b0, req1_ready}, 0);
    end
    consume();
    wait_accept(id);
    check("t4_grant", id, 1);
    wait_valid(5);
    consume();

    // reset mid-job
    req0_a = 4'd10; req0_b = 4'd10; req0_valid = 1'b1;
    wait_accept(id);
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_resp_valid", {31'b0, resp_valid}, 0);
    check("abort_busy",       {31'b0, busy}, 0);
    check("abort_product",    {24'b0, resp_product}, 0);
    check("abort_id",         {31'b0, resp_id}, 0);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    repeat (3) tick();
    check("abort_no_resp", {31'b0, resp_valid}, 0);
    rst_n = 1'b1;
    tick();
    req1_a = 4'd6; req1_b = 4'd7; req1_valid = 1'b1;
    wait_accept(id);
    check("t5_grant", id, 1);
    wait_valid(5);
    consume();

    // enable freeze in IDLE, RUN and RESP
    ena = 1'b0;
    req0_a = 4'd3; req0_b = 4'd5; req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check("ena_idle_ready", {31'b0, req0_ready}, 0);
      check("ena_idle_busy",  {31'b0, busy}, 0);
    end
    ena = 1'b1;
    wait_accept(id);
    req0_a = 4'd15; req0_b = 4'd15;
    tick();
    ena = 1'b0;
    repeat (3) tick();
    ena = 1'b1;
    wait_valid(8);
    ena = 1'b0;
    resp_ready = 1'b1;
    repeat (2) tick();
    check("ena_resp_hold", {31'b0, resp_valid}, 1);
    ena = 1'b1;
    consume();

    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
